// File: rtl/mst_arbiter.sv
// mst_arbiter
//   Packet-atomic round-robin arbiter. It shares the single bus-master command
//   FIFO (18-bit words toward pcie_tlp) between two receiver engines. A grant
//   lasts for one whole TLP. Data passes through combinationally. The block
//   also keeps per-port completed-TLP counters and a stall watchdog.
//
// Ports
//   sys_clk, sys_rst_n     clock (clk_125 domain), async active-low reset
//   reqN_req               port N has a TLP pending or in progress
//   reqN_din[17:0]         bit17 = TLP start, bit16 = TLP end, [15:0] payload
//   reqN_wr_en             port N write strobe
//   reqN_full              backpressure to port N (high unless N is granted)
//   mst_din, mst_wr_en     write side of the master FIFO
//   mst_full               master FIFO full
//   err_clr                pulse that clears timeout_err
//   grant[1:0]             one-hot current grant, 00 = idle
//   tlp_cnt0/1[15:0]       TLPs completed per port (wrapping)
//   timeout_err[1:0]       sticky watchdog flags, one per port
module mst_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req0_req,
    input  logic [17:0] req0_din,
    input  logic        req0_wr_en,
    output logic        req0_full,
    input  logic        req1_req,
    input  logic [17:0] req1_din,
    input  logic        req1_wr_en,
    output logic        req1_full,
    output logic [17:0] mst_din,
    output logic        mst_wr_en,
    input  logic        mst_full,
    input  logic        err_clr,
    output logic [1:0]  grant,
    output logic [15:0] tlp_cnt0,
    output logic [15:0] tlp_cnt1,
    output logic [1:0]  timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    // The watchdog fires on the tick that would take it to TIMEOUT.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [15:0]     tlp_cnt0_q, tlp_cnt0_d;
    logic [15:0]     tlp_cnt1_q, tlp_cnt1_d;
    logic [1:0]      timeout_err_q, timeout_err_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic acc0, acc1, cur, acc, end_word, wd_tick, timeout;

    // Round-robin pick. p is the port that last held the bus. Prefer the
    // other port, fall back to p, otherwise go idle.
    function automatic state_e pick(input logic p, input logic r0, input logic r1);
        state_e s;
        s = IDLE;
        if (p) begin
            if (r0)      s = GRANT0;
            else if (r1) s = GRANT1;
        end else begin
            if (r1)      s = GRANT1;
            else if (r0) s = GRANT0;
        end
        return s;
    endfunction

    // Zero-latency data path and backpressure.
    assign req0_full   = (state_q != GRANT0) | mst_full;
    assign req1_full   = (state_q != GRANT1) | mst_full;
    assign acc0        = req0_wr_en & ~req0_full;
    assign acc1        = req1_wr_en & ~req1_full;
    assign mst_wr_en   = acc0 | acc1;
    assign mst_din     = (state_q == GRANT1) ? req1_din : req0_din;
    assign grant       = {state_q == GRANT1, state_q == GRANT0};
    assign tlp_cnt0    = tlp_cnt0_q;
    assign tlp_cnt1    = tlp_cnt1_q;
    assign timeout_err = timeout_err_q;

    // Only the granted port can have an accepted word, so these terms are
    // meaningful only in the GRANT states.
    assign cur      = (state_q == GRANT1);
    assign acc      = cur ? acc1 : acc0;
    assign end_word = acc & (cur ? req1_din[16] : req0_din[16]);
    assign wd_tick  = ~acc & ~mst_full;
    assign timeout  = wd_tick & (wd_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        tlp_cnt0_d    = tlp_cnt0_q;
        tlp_cnt1_d    = tlp_cnt1_q;
        timeout_err_d = err_clr ? 2'b00 : timeout_err_q;
        wd_d          = wd_q;
        case (state_q)
            IDLE: begin
                if (req0_req | req1_req) begin
                    state_d = pick(last_q, req0_req, req1_req);
                    wd_d    = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (end_word | timeout) begin
                    last_d  = cur;
                    state_d = pick(cur, req0_req, req1_req);
                    wd_d    = '0;
                    if (end_word) begin
                        if (cur) tlp_cnt1_d = tlp_cnt1_q + 16'd1;
                        else     tlp_cnt0_d = tlp_cnt0_q + 16'd1;
                    end else begin
                        // A timeout overrides err_clr in the same cycle.
                        timeout_err_d[cur] = 1'b1;
                    end
                end else if (acc) begin
                    wd_d = '0;
                end else if (wd_tick) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            tlp_cnt0_q    <= '0;
            tlp_cnt1_q    <= '0;
            timeout_err_q <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            tlp_cnt0_q    <= tlp_cnt0_d;
            tlp_cnt1_q    <= tlp_cnt1_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

endmodule

// File: tb/tb_mst_arbiter.sv
`timescale 1ns/1ps
module tb_mst_arbiter;

    localparam int unsigned TO = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        req0_req, req0_wr_en, req0_full;
    logic        req1_req, req1_wr_en, req1_full;
    logic [17:0] req0_din, req1_din, mst_din;
    logic        mst_wr_en, mst_full, err_clr;
    logic [1:0]  grant, timeout_err;
    logic [15:0] tlp_cnt0, tlp_cnt1;

    typedef struct packed {
        logic        port;
        logic [17:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] w0[$], w1[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;
    int          cyc;

    mst_arbiter #(.TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req0_req(req0_req), .req0_din(req0_din), .req0_wr_en(req0_wr_en), .req0_full(req0_full),
        .req1_req(req1_req), .req1_din(req1_din), .req1_wr_en(req1_wr_en), .req1_full(req1_full),
        .mst_din(mst_din), .mst_wr_en(mst_wr_en), .mst_full(mst_full), .err_clr(err_clr),
        .grant(grant), .tlp_cnt0(tlp_cnt0), .tlp_cnt1(tlp_cnt1), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected word.
    exp_t e;
    initial forever begin
        @(negedge sys_clk);
        #2;
        if (mon_en && mst_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'd0, mst_wr_en}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mst_din", {14'd0, mst_din}, {14'd0, e.data});
                chk("write_grant", {30'd0, grant}, e.port ? 2 : 1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic push(input bit p, input logic [17:0] d);
        exp_q.push_back({p, d});
    endtask

    task automatic gen_tlp(input bit p, input int len);
        logic [17:0] w;
        for (int k = 0; k < len; k++) begin
            w = {k == 0, k == len - 1, 16'($urandom)};
            if (p) w1.push_back(w); else w0.push_back(w);
        end
    endtask

    // Reference: whole TLPs alternate between ports, starting with 'first',
    // falling back to whichever port still has TLPs.
    task automatic model_push(input bit first);
        int i = 0;
        int j = 0;
        bit pref = first;
        bit p;
        while (i < w0.size() || j < w1.size()) begin
            if (!pref) p = (i < w0.size()) ? 1'b0 : 1'b1;
            else       p = (j < w1.size()) ? 1'b1 : 1'b0;
            if (!p) begin
                do begin push(1'b0, w0[i]); i++; end while (i < w0.size() && !w0[i-1][16]);
            end else begin
                do begin push(1'b1, w1[j]); j++; end while (j < w1.size() && !w1[j-1][16]);
            end
            pref = ~p;
        end
    endtask

    // Receiver-like drivers: req held while words remain, dropped on the
    // final word once granted; idle ports strobe stray wr_en.
    task automatic run_traffic(input int gap, input int fpct, output int ncyc);
        int p0 = 0, p1 = 0, rem0, rem1;
        bit a0 = 0, a1 = 0;
        ncyc = 0;
        forever begin
            @(negedge sys_clk);
            ncyc++;
            if (a0) p0++;
            if (a1) p1++;
            rem0 = w0.size() - p0;
            rem1 = w1.size() - p1;
            if ((rem0 == 0 && rem1 == 0) || ncyc > 3000) break;
            mst_full   = ($urandom_range(99) < fpct);
            req0_req   = (rem0 > 1) || (rem0 == 1 && !grant[0]);
            req1_req   = (rem1 > 1) || (rem1 == 1 && !grant[1]);
            req0_wr_en = (rem0 > 0) ? ($urandom_range(99) >= gap) : 1'($urandom_range(1));
            req1_wr_en = (rem1 > 0) ? ($urandom_range(99) >= gap) : 1'($urandom_range(1));
            req0_din   = (rem0 > 0) ? w0[p0] : 18'($urandom);
            req1_din   = (rem1 > 0) ? w1[p1] : 18'($urandom);
            #1;
            a0 = req0_wr_en && !req0_full;
            a1 = req1_wr_en && !req1_full;
        end
        req0_req = 0; req1_req = 0; req0_wr_en = 0; req1_wr_en = 0; mst_full = 0;
        chk("traffic_drained", p0 + p1, w0.size() + w1.size());
        w0.delete();
        w1.delete();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        req0_req = 0; req1_req = 0; req0_wr_en = 0; req1_wr_en = 0;
        req0_din = '0; req1_din = '0; mst_full = 0; err_clr = 0;
        sys_rst_n = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1;
        chk("sb_empty_at_reset", exp_q.size(), 0);
    endtask

    initial begin
        int n0, n1;
        sys_rst_n = 1;
        req0_req = 0; req1_req = 0; req0_wr_en = 0; req1_wr_en = 0;
        req0_din = '0; req1_din = '0; mst_full = 0; err_clr = 0;
        #1 sys_rst_n = 0;
        #2;
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_full0", {31'd0, req0_full}, 1);
        chk("rst_full1", {31'd0, req1_full}, 1);
        chk("rst_wr_en", {31'd0, mst_wr_en}, 0);
        chk("rst_cnt0", {16'd0, tlp_cnt0}, 0);
        chk("rst_cnt1", {16'd0, tlp_cnt1}, 0);
        chk("rst_err", {30'd0, timeout_err}, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1;

        // Port 0 alone, 4-word TLP, with port 1 strobing junk.
        req0_req = 1; req1_wr_en = 1; req1_din = 18'h3_5555;
        @(negedge sys_clk);
        chk("grant_latency", {30'd0, grant}, 1);
        chk("req0_full_granted", {31'd0, req0_full}, 0);
        chk("req1_full_blocked", {31'd0, req1_full}, 1);
        gen_tlp(1'b0, 4);
        model_push(1'b0);
        run_traffic(0, 0, cyc);
        chk("cnt0_single", {16'd0, tlp_cnt0}, 1);
        chk("idle_after_tlp", {30'd0, grant}, 0);

        // Both ports, back-to-back 3-word TLPs.
        do_reset();
        for (int k = 0; k < 5; k++) begin gen_tlp(1'b0, 3); gen_tlp(1'b1, 3); end
        model_push(1'b0);
        run_traffic(0, 0, cyc);
        chk("b2b_cycles", cyc, 32);
        chk("b2b_cnt0", {16'd0, tlp_cnt0}, 5);
        chk("b2b_cnt1", {16'd0, tlp_cnt1}, 5);

        // mst_full stall mid-TLP on port 1 for 20 cycles.
        do_reset();
        req1_req = 1;
        @(negedge sys_clk);
        chk("grant1_latency", {30'd0, grant}, 2);
        req1_din = 18'h2_A001; req1_wr_en = 1; push(1'b1, 18'h2_A001);
        @(negedge sys_clk);
        mst_full = 1; req1_din = 18'h1_A002;
        repeat (20) @(negedge sys_clk);
        chk("stall_full1", {31'd0, req1_full}, 1);
        chk("stall_no_err", {30'd0, timeout_err}, 0);
        chk("stall_grant", {30'd0, grant}, 2);
        mst_full = 0; req1_req = 0; push(1'b1, 18'h1_A002);
        @(negedge sys_clk);
        req1_wr_en = 0;
        chk("stall_done_grant", {30'd0, grant}, 0);
        chk("stall_cnt1", {16'd0, tlp_cnt1}, 1);
        chk("stall_err", {30'd0, timeout_err}, 0);

        // Watchdog: port 0 goes silent after its start word.
        do_reset();
        req0_req = 1;
        @(negedge sys_clk);
        req0_din = 18'h2_1234; req0_wr_en = 1; push(1'b0, 18'h2_1234);
        req0_req = 0; req1_req = 1;
        @(negedge sys_clk);
        req0_wr_en = 0;
        repeat (15) @(negedge sys_clk);
        chk("wd_before_grant", {30'd0, grant}, 1);
        chk("wd_before_err", {30'd0, timeout_err}, 0);
        @(negedge sys_clk);
        chk("wd_fire_grant", {30'd0, grant}, 2);
        chk("wd_fire_err", {30'd0, timeout_err}, 1);
        chk("wd_cnt0", {16'd0, tlp_cnt0}, 0);
        err_clr = 1;
        @(negedge sys_clk);
        err_clr = 0;
        chk("err_clr", {30'd0, timeout_err}, 0);
        req1_din = 18'h3_5A5A; req1_wr_en = 1; req1_req = 0; push(1'b1, 18'h3_5A5A);
        @(negedge sys_clk);
        req1_wr_en = 0;
        chk("single_word_release", {30'd0, grant}, 0);
        chk("single_word_cnt1", {16'd0, tlp_cnt1}, 1);

        // Randomized traffic with gaps and backpressure.
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 12; k++) begin
            gen_tlp(1'b0, $urandom_range(1, 5)); n0++;
            gen_tlp(1'b1, $urandom_range(1, 5)); n1++;
        end
        model_push(1'b0);
        run_traffic(25, 20, cyc);
        chk("rand_cnt0", {16'd0, tlp_cnt0}, n0);
        chk("rand_cnt1", {16'd0, tlp_cnt1}, n1);
        chk("rand_err", {30'd0, timeout_err}, 0);

        // Counter wrap with back-to-back single-word TLPs, then async reset.
        do_reset();
        mon_en = 0;
        req0_req = 1; req0_wr_en = 1; req0_din = 18'h3_0000;
        repeat (65536) @(negedge sys_clk);
        chk("cnt0_max", {16'd0, tlp_cnt0}, 32'hFFFF);
        @(negedge sys_clk);
        chk("cnt0_wrap", {16'd0, tlp_cnt0}, 0);
        @(negedge sys_clk);
        mon_en = 1;
        req0_din = 18'h2_BEEF; push(1'b0, 18'h2_BEEF);
        @(negedge sys_clk);
        req0_din = 18'h0_0001;
        #1 sys_rst_n = 0;
        #1;
        chk("arst_grant", {30'd0, grant}, 0);
        chk("arst_full0", {31'd0, req0_full}, 1);
        chk("arst_full1", {31'd0, req1_full}, 1);
        chk("arst_wr_en", {31'd0, mst_wr_en}, 0);
        chk("arst_cnt0", {16'd0, tlp_cnt0}, 0);
        req0_req = 0; req0_wr_en = 0;
        @(negedge sys_clk);
        sys_rst_n = 1;
        @(negedge sys_clk);
        chk("sb_empty_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
